rs_param: RTL and testbench
===========================

# rs_param

Parametrised reservation station between rename/dispatch and the functional units (FUs). Holds up to `NUM_ENTRIES` renamed instructions, captures tag wakeups broadcast by the complete stage, and issues one ready instruction per FU per cycle. Supersedes the fixed 16-entry, 2-in/3-out station with:
- parametrised depth, dispatch, issue and wakeup widths;
- a dispatch valid/ready handshake;
- per-operand ready tracking;
- a flush input.

## Interface
- `NUM_ENTRIES`, 16, station depth (≥ `DISPATCH_W`)
- `DISPATCH_W`, 2, dispatch lanes per cycle
- `ISSUE_W`, 3, FU count, one issue port per FU
- `WAKEUP_W`, 2, completion tag broadcasts per cycle
- `TAG_W`, 6, physical register tag width
- `OP_W`, 8, opaque op payload width
- `FU_W`, `$clog2(ISSUE_W)`, FU select width (derived)

- `i_clk`  in  1  clock, all state on rising edge
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_flush`  in  1  synchronous clear of all entries
- `i_disp_valid`  in  `DISPATCH_W`  per-lane dispatch valid
- `i_disp_op`  in  `DISPATCH_W`×`OP_W`  op payload
- `i_disp_fu`  in  `DISPATCH_W`×`FU_W`  target FU index
- `i_disp_dst`  in  `DISPATCH_W`×`TAG_W`  destination tag
- `i_disp_src1`, `i_disp_src2`  in  `DISPATCH_W`×`TAG_W`  source tags
- `i_disp_rdy1`, `i_disp_rdy2`  in  `DISPATCH_W`  source already available
- `o_disp_ready`  out  1  station can accept a full dispatch group
- `i_wake_valid`  in  `WAKEUP_W`  completion broadcast valid
- `i_wake_tag`  in  `WAKEUP_W`×`TAG_W`  completed destination tag
- `i_fu_ready`  in  `ISSUE_W`  FU can accept an op this cycle
- `o_iss_valid`  out  `ISSUE_W`  issue port valid
- `o_iss_op`, `o_iss_dst`, `o_iss_src1`, `o_iss_src2`  out  `ISSUE_W`×width  issued entry fields
- `o_free_count`  out  `$clog2(NUM_ENTRIES+1)`  registered count of free entries

## Operation
- Each entry holds: `valid`, `op`, `fu`, `dst`, `src1`/`rdy1`, `src2`/`rdy2`. An entry is eligible when `valid & rdy1 & rdy2`.
- **Dispatch handshake**
  - `o_disp_ready = (o_free_count >= DISPATCH_W)`. The group is all-or-nothing.
  - A lane transfers when `i_disp_valid[k] & o_disp_ready`. Lanes may be sparse.
  - The k-th valid lane writes the k-th lowest-index free entry.
  - When `o_disp_ready=0`, lanes are ignored and upstream holds.
- **Wakeup**
  - Each valid `i_wake_tag` matching a stored src tag sets that `rdy` bit at the edge.
  - Dispatch bypass: a dispatching lane whose src tag matches a same-cycle wakeup is written with `rdy=1`.
  - Tags already ready are unaffected.
- **Select**
  - For each FU f, pick the lowest-index eligible entry with `fu==f`.
  - Drive its fields on port f and set `o_iss_valid[f]=1`. This is combinational from registered entry state, independent of `i_fu_ready`.
  - Issue completes when `o_iss_valid[f] & i_fu_ready[f]`; the entry's `valid` clears at that edge.
  - An entry targets exactly one FU, so no entry issues twice.
- **Free count**
  - Next value = current − accepted dispatches + completed issues.
  - Entries freed this cycle are not reallocated until the next cycle, because allocation uses pre-edge `valid`.
- **Flush**: all `valid` clear at the edge. Dispatch, wakeup and issue in the same cycle are discarded, and `o_free_count` becomes `NUM_ENTRIES`.
- **Reset** (asynchronous, any cycle, including mid-dispatch): all `valid`/`rdy` cleared, `o_free_count=NUM_ENTRIES`, `o_disp_ready=1`, `o_iss_valid=0`, issue data ports 0.

## Timing
- Dispatch at edge N: the entry is visible from cycle N+1. If both sources are ready, it can issue in cycle N+1 (1-cycle dispatch-to-issue).
- Wakeup in cycle N sets `rdy` at edge N; the dependent op can issue in cycle N+1. There is no same-cycle wakeup-to-select path.
- `o_iss_valid`/fields are stable until `i_fu_ready` accepts them, unless a lower-index entry becomes eligible. Ports carry no hold guarantee; FUs sample only on accept.
- `o_disp_ready` and `o_free_count` are registered-state functions, so there is no combinational path from `i_fu_ready`.
- Throughput: `DISPATCH_W` in and `ISSUE_W` out per cycle, sustained.

## Test plan
- **Reset/fill**: after reset, `o_free_count=16` and `o_disp_ready=1`. Dispatch 8 groups of 2 ready ops to FU0 with `i_fu_ready=0` → entries 0..15 fill, `o_free_count=0`, `o_disp_ready=0`, and a 9th group is ignored.
- **Full boundary**: at `o_free_count=2` dispatch 2 → count 0. Then assert `i_fu_ready[0]` for 1 cycle → entry 0 issues, count 1, `o_disp_ready` stays 0 (1 < 2).
- **Wakeup chain**: dispatch op A (`dst=5`, FU1, ready) and op B (`src1=5`, `rdy1=0`, FU2) at cycle 0 → A issues cycle 1. A wakeup on tag 5 in cycle 3 → B issues cycle 4.
- **Dispatch bypass**: dispatch op with `src2=9`, `rdy2=0`, while `i_wake_tag=9` valid in the same cycle → the op issues the next cycle.
- **Parallel issue and priority**: ready ops in entries 3 (FU0), 7 (FU1), 2 (FU2) and 1 (FU0), all FUs ready → one cycle issues entries 1, 7 and 2; entry 3 issues the next cycle; count +3 then +1.
- **Flush/async reset**: with 10 entries valid, pulse `i_flush` with a dispatch → count 16 and no issue next cycle. Assert `i_rst_n=0` mid-cycle → `o_iss_valid` drops to 0 immediately.

Source files
------------

// File: rtl/rs_param.sv
// rs_param: parametrised reservation station.
// Holds renamed ops until both sources are ready. Captures completion-tag
// wakeups and issues the lowest-index eligible op to each functional unit.
// Dispatch is an all-or-nothing group handshake gated on the registered
// free-entry count.
module rs_param #(
    parameter int NUM_ENTRIES = 16,
    parameter int DISPATCH_W  = 2,
    parameter int ISSUE_W     = 3,
    parameter int WAKEUP_W    = 2,
    parameter int TAG_W       = 6,
    parameter int OP_W        = 8,
    parameter int FU_W        = $clog2(ISSUE_W)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_flush,
    // dispatch
    input  logic [DISPATCH_W-1:0]                  i_disp_valid,
    input  logic [DISPATCH_W-1:0][OP_W-1:0]        i_disp_op,
    input  logic [DISPATCH_W-1:0][FU_W-1:0]        i_disp_fu,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]       i_disp_dst,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]       i_disp_src1,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]       i_disp_src2,
    input  logic [DISPATCH_W-1:0]                  i_disp_rdy1,
    input  logic [DISPATCH_W-1:0]                  i_disp_rdy2,
    output logic                                   o_disp_ready,
    // wakeup
    input  logic [WAKEUP_W-1:0]                    i_wake_valid,
    input  logic [WAKEUP_W-1:0][TAG_W-1:0]         i_wake_tag,
    // issue
    input  logic [ISSUE_W-1:0]                     i_fu_ready,
    output logic [ISSUE_W-1:0]                     o_iss_valid,
    output logic [ISSUE_W-1:0][OP_W-1:0]           o_iss_op,
    output logic [ISSUE_W-1:0][TAG_W-1:0]          o_iss_dst,
    output logic [ISSUE_W-1:0][TAG_W-1:0]          o_iss_src1,
    output logic [ISSUE_W-1:0][TAG_W-1:0]          o_iss_src2,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]       o_free_count
);

    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    // entry state
    logic [NUM_ENTRIES-1:0]             valid_q, valid_d;
    logic [NUM_ENTRIES-1:0]             rdy1_q,  rdy1_d;
    logic [NUM_ENTRIES-1:0]             rdy2_q,  rdy2_d;
    logic [NUM_ENTRIES-1:0][OP_W-1:0]   op_q,    op_d;
    logic [NUM_ENTRIES-1:0][FU_W-1:0]   fu_q,    fu_d;
    logic [NUM_ENTRIES-1:0][TAG_W-1:0]  dst_q,   dst_d;
    logic [NUM_ENTRIES-1:0][TAG_W-1:0]  src1_q,  src1_d;
    logic [NUM_ENTRIES-1:0][TAG_W-1:0]  src2_q,  src2_d;
    logic [CNT_W-1:0]                   free_cnt_q, free_cnt_d;

    // allocation
    logic [NUM_ENTRIES-1:0]             alloc_taken;
    logic [DISPATCH_W-1:0]              lane_go;
    logic [DISPATCH_W-1:0][IDX_W-1:0]   lane_slot;
    logic [DISPATCH_W-1:0]              lane_wake1;
    logic [DISPATCH_W-1:0]              lane_wake2;

    // select
    logic [ISSUE_W-1:0]                 sel_found;
    logic [ISSUE_W-1:0][IDX_W-1:0]      sel_idx;

    int unsigned                        n_disp;
    int unsigned                        n_iss;

    assign o_disp_ready = (free_cnt_q >= CNT_W'(DISPATCH_W));
    assign o_free_count = free_cnt_q;

    // Map the k-th valid lane onto the k-th lowest free entry (pre-edge valid only),
    // and detect same-cycle wakeups of each lane's source tags.
    always_comb begin
        alloc_taken = '0;
        lane_go     = '0;
        lane_slot   = '0;
        lane_wake1  = '0;
        lane_wake2  = '0;
        for (int unsigned k = 0; k < DISPATCH_W; k++) begin
            if (i_disp_valid[k] && o_disp_ready) begin
                for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
                    if (!valid_q[e] && !alloc_taken[e] && !lane_go[k]) begin
                        lane_go[k]     = 1'b1;
                        lane_slot[k]   = IDX_W'(e);
                        alloc_taken[e] = 1'b1;
                    end
                end
            end
            for (int unsigned w = 0; w < WAKEUP_W; w++) begin
                if (i_wake_valid[w] && (i_wake_tag[w] == i_disp_src1[k])) lane_wake1[k] = 1'b1;
                if (i_wake_valid[w] && (i_wake_tag[w] == i_disp_src2[k])) lane_wake2[k] = 1'b1;
            end
        end
    end

    // Per-FU select of the lowest-index eligible entry, driven straight onto the ports.
    always_comb begin
        sel_found  = '0;
        sel_idx    = '0;
        o_iss_valid = '0;
        o_iss_op    = '0;
        o_iss_dst   = '0;
        o_iss_src1  = '0;
        o_iss_src2  = '0;
        for (int unsigned f = 0; f < ISSUE_W; f++) begin
            for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
                if (valid_q[e] && rdy1_q[e] && rdy2_q[e] &&
                    (fu_q[e] == FU_W'(f)) && !sel_found[f]) begin
                    sel_found[f] = 1'b1;
                    sel_idx[f]   = IDX_W'(e);
                end
            end
            if (sel_found[f]) begin
                o_iss_valid[f] = 1'b1;
                o_iss_op[f]    = op_q[sel_idx[f]];
                o_iss_dst[f]   = dst_q[sel_idx[f]];
                o_iss_src1[f]  = src1_q[sel_idx[f]];
                o_iss_src2[f]  = src2_q[sel_idx[f]];
            end
        end
    end

    // Next entry state: wakeups, issue retirement, dispatch writes, free count, flush.
    // Dispatch only targets entries invalid before the edge, so it never collides
    // with an entry retiring this cycle.
    always_comb begin
        valid_d    = valid_q;
        rdy1_d     = rdy1_q;
        rdy2_d     = rdy2_q;
        op_d       = op_q;
        fu_d       = fu_q;
        dst_d      = dst_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        n_disp     = 0;
        n_iss      = 0;

        for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
            for (int unsigned w = 0; w < WAKEUP_W; w++) begin
                if (i_wake_valid[w] && (i_wake_tag[w] == src1_q[e])) rdy1_d[e] = 1'b1;
                if (i_wake_valid[w] && (i_wake_tag[w] == src2_q[e])) rdy2_d[e] = 1'b1;
            end
        end

        for (int unsigned f = 0; f < ISSUE_W; f++) begin
            if (sel_found[f] && i_fu_ready[f]) begin
                valid_d[sel_idx[f]] = 1'b0;
                n_iss = n_iss + 1;
            end
        end

        for (int unsigned k = 0; k < DISPATCH_W; k++) begin
            if (lane_go[k]) begin
                valid_d[lane_slot[k]] = 1'b1;
                op_d[lane_slot[k]]    = i_disp_op[k];
                fu_d[lane_slot[k]]    = i_disp_fu[k];
                dst_d[lane_slot[k]]   = i_disp_dst[k];
                src1_d[lane_slot[k]]  = i_disp_src1[k];
                src2_d[lane_slot[k]]  = i_disp_src2[k];
                rdy1_d[lane_slot[k]]  = i_disp_rdy1[k] | lane_wake1[k];
                rdy2_d[lane_slot[k]]  = i_disp_rdy2[k] | lane_wake2[k];
                n_disp = n_disp + 1;
            end
        end

        free_cnt_d = free_cnt_q + CNT_W'(n_iss) - CNT_W'(n_disp);

        if (i_flush) begin
            valid_d    = '0;
            rdy1_d     = '0;
            rdy2_d     = '0;
            free_cnt_d = CNT_W'(NUM_ENTRIES);
        end
    end

    // Entry and free-count registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= '0;
            rdy1_q     <= '0;
            rdy2_q     <= '0;
            op_q       <= '0;
            fu_q       <= '0;
            dst_q      <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            free_cnt_q <= CNT_W'(NUM_ENTRIES);
        end else begin
            valid_q    <= valid_d;
            rdy1_q     <= rdy1_d;
            rdy2_q     <= rdy2_d;
            op_q       <= op_d;
            fu_q       <= fu_d;
            dst_q      <= dst_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            free_cnt_q <= free_cnt_d;
        end
    end

endmodule

// File: tb/tb_rs_param.sv
// Directed testbench for rs_param with default parameters.
module tb_rs_param;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [1:0]       disp_valid;
    logic [1:0][7:0]  disp_op;
    logic [1:0][1:0]  disp_fu;
    logic [1:0][5:0]  disp_dst;
    logic [1:0][5:0]  disp_src1;
    logic [1:0][5:0]  disp_src2;
    logic [1:0]       disp_rdy1;
    logic [1:0]       disp_rdy2;
    logic             disp_ready;
    logic [1:0]       wake_valid;
    logic [1:0][5:0]  wake_tag;
    logic [2:0]       fu_ready;
    logic [2:0]       iss_valid;
    logic [2:0][7:0]  iss_op;
    logic [2:0][5:0]  iss_dst;
    logic [2:0][5:0]  iss_src1;
    logic [2:0][5:0]  iss_src2;
    logic [4:0]       free_count;

    int checks   = 0;
    int failures = 0;

    rs_param #(
        .NUM_ENTRIES (16),
        .DISPATCH_W  (2),
        .ISSUE_W     (3),
        .WAKEUP_W    (2),
        .TAG_W       (6),
        .OP_W        (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_disp_valid (disp_valid),
        .i_disp_op    (disp_op),
        .i_disp_fu    (disp_fu),
        .i_disp_dst   (disp_dst),
        .i_disp_src1  (disp_src1),
        .i_disp_src2  (disp_src2),
        .i_disp_rdy1  (disp_rdy1),
        .i_disp_rdy2  (disp_rdy2),
        .o_disp_ready (disp_ready),
        .i_wake_valid (wake_valid),
        .i_wake_tag   (wake_tag),
        .i_fu_ready   (fu_ready),
        .o_iss_valid  (iss_valid),
        .o_iss_op     (iss_op),
        .o_iss_dst    (iss_dst),
        .o_iss_src1   (iss_src1),
        .o_iss_src2   (iss_src2),
        .o_free_count (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the directed sequence somehow stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lane(input int k, input logic [7:0] op, input logic [1:0] fu,
                        input logic [5:0] dst, input logic [5:0] s1, input logic r1,
                        input logic [5:0] s2, input logic r2);
        disp_op[k]   = op;
        disp_fu[k]   = fu;
        disp_dst[k]  = dst;
        disp_src1[k] = s1;
        disp_rdy1[k] = r1;
        disp_src2[k] = s2;
        disp_rdy2[k] = r2;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        disp_valid = '0;
        disp_op    = '0;
        disp_fu    = '0;
        disp_dst   = '0;
        disp_src1  = '0;
        disp_src2  = '0;
        disp_rdy1  = '0;
        disp_rdy2  = '0;
        wake_valid = '0;
        wake_tag   = '0;
        fu_ready   = '0;

        // ---- reset state
        tick();
        tick();
        chk("rst_free",   32'(free_count), 32'd16);
        chk("rst_ready",  32'(disp_ready), 32'd1);
        chk("rst_issv",   32'(iss_valid),  32'd0);
        chk("rst_op0",    32'(iss_op[0]),  32'd0);
        rst_n = 1'b1;

        // ---- fill 16 entries with ready FU0 ops, entry e carries op 0x40+e
        for (int g = 0; g < 8; g++) begin
            lane(0, 8'(8'h40 + 2*g), 2'd0, 6'(2*g),   6'd1, 1'b1, 6'd2, 1'b1);
            lane(1, 8'(8'h41 + 2*g), 2'd0, 6'(2*g+1), 6'd1, 1'b1, 6'd2, 1'b1);
            disp_valid = 2'b11;
            tick();
            chk("fill_free", 32'(free_count), 32'(16 - 2*(g+1)));
        end
        chk("full_ready", 32'(disp_ready), 32'd0);
        chk("full_issv",  32'(iss_valid),  32'b001);
        chk("full_op0",   32'(iss_op[0]),  32'h40);

        // 9th group must be ignored
        lane(0, 8'hAA, 2'd0, 6'd30, 6'd1, 1'b1, 6'd2, 1'b1);
        lane(1, 8'hAB, 2'd0, 6'd31, 6'd1, 1'b1, 6'd2, 1'b1);
        tick();
        chk("ovf_free", 32'(free_count), 32'd0);
        chk("ovf_op0",  32'(iss_op[0]),  32'h40);

        // accept entry 0 for one cycle
        disp_valid = '0;
        fu_ready   = 3'b001;
        tick();
        fu_ready   = '0;
        chk("acc1_free",  32'(free_count), 32'd1);
        chk("acc1_ready", 32'(disp_ready), 32'd0);
        chk("acc1_op0",   32'(iss_op[0]),  32'h41);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl1_free",  32'(free_count), 32'd16);
        chk("fl1_issv",  32'(iss_valid),  32'd0);
        chk("fl1_ready", 32'(disp_ready), 32'd1);

        // ---- wakeup chain: A (dst 5, FU1, ready), B (src1 5 not ready, FU2)
        fu_ready = 3'b111;
        lane(0, 8'hA1, 2'd1, 6'd5, 6'd1, 1'b1, 6'd2, 1'b1);
        lane(1, 8'hB2, 2'd2, 6'd7, 6'd5, 1'b0, 6'd3, 1'b1);
        disp_valid = 2'b11;
        tick();
        disp_valid = '0;
        chk("wk_c1_issv", 32'(iss_valid),  32'b010);
        chk("wk_c1_op1",  32'(iss_op[1]),  32'hA1);
        chk("wk_c1_dst1", 32'(iss_dst[1]), 32'd5);
        chk("wk_c1_free", 32'(free_count), 32'd14);
        tick();
        chk("wk_c2_free", 32'(free_count), 32'd15);
        chk("wk_c2_issv", 32'(iss_valid),  32'd0);
        // matching tags on invalid wake lanes must not wake B
        wake_tag   = {6'd5, 6'd5};
        wake_valid = 2'b00;
        tick();
        chk("wk_c3_issv", 32'(iss_valid), 32'd0);
        wake_tag   = {6'd5, 6'd6};
        wake_valid = 2'b10;
        #1;
        chk("wk_nocomb",  32'(iss_valid), 32'd0);
        tick();
        wake_valid = '0;
        chk("wk_c4_issv", 32'(iss_valid),   32'b100);
        chk("wk_c4_op2",  32'(iss_op[2]),   32'hB2);
        chk("wk_c4_s1",   32'(iss_src1[2]), 32'd5);
        chk("wk_c4_s2",   32'(iss_src2[2]), 32'd3);
        tick();
        chk("wk_c5_free", 32'(free_count), 32'd16);
        chk("wk_c5_issv", 32'(iss_valid),  32'd0);

        // ---- dispatch bypass on sparse lane 1, then non-matching wake on lane 0
        fu_ready = '0;
        lane(1, 8'hC3, 2'd0, 6'd8, 6'd3, 1'b1, 6'd9, 1'b0);
        disp_valid  = 2'b10;
        wake_tag[0] = 6'd9;
        wake_valid  = 2'b01;
        tick();
        chk("byp_issv", 32'(iss_valid),  32'b001);
        chk("byp_op0",  32'(iss_op[0]),  32'hC3);
        chk("byp_free", 32'(free_count), 32'd15);
        lane(0, 8'hD4, 2'd1, 6'd11, 6'd4, 1'b1, 6'd10, 1'b0);
        disp_valid  = 2'b01;
        wake_tag[0] = 6'd12;
        tick();
        disp_valid = '0;
        wake_valid = '0;
        chk("nbyp_issv", 32'(iss_valid),  32'b001);
        chk("nbyp_free", 32'(free_count), 32'd14);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl2_free", 32'(free_count), 32'd16);

        // ---- parallel issue / priority: ready entries 1(FU0) 2(FU2) 3(FU0) 7(FU1)
        lane(0, 8'h00, 2'd0, 6'd20, 6'd40, 1'b0, 6'd2, 1'b1);
        lane(1, 8'h11, 2'd0, 6'd21, 6'd1,  1'b1, 6'd2, 1'b1);
        disp_valid = 2'b11;
        tick();
        lane(0, 8'h22, 2'd2, 6'd22, 6'd1,  1'b1, 6'd2, 1'b1);
        lane(1, 8'h33, 2'd0, 6'd23, 6'd1,  1'b1, 6'd2, 1'b1);
        tick();
        lane(0, 8'h44, 2'd1, 6'd24, 6'd40, 1'b0, 6'd2, 1'b1);
        lane(1, 8'h55, 2'd2, 6'd25, 6'd40, 1'b0, 6'd2, 1'b1);
        tick();
        lane(0, 8'h66, 2'd0, 6'd26, 6'd40, 1'b0, 6'd2, 1'b1);
        lane(1, 8'h77, 2'd1, 6'd27, 6'd1,  1'b1, 6'd2, 1'b1);
        tick();
        disp_valid = '0;
        chk("pri_free0", 32'(free_count), 32'd8);
        chk("pri_issv0", 32'(iss_valid),  32'b111);
        chk("pri_op0",   32'(iss_op[0]),  32'h11);
        chk("pri_op1",   32'(iss_op[1]),  32'h77);
        chk("pri_op2",   32'(iss_op[2]),  32'h22);
        fu_ready = 3'b111;
        tick();
        chk("pri_free1", 32'(free_count), 32'd11);
        chk("pri_issv1", 32'(iss_valid),  32'b001);
        chk("pri_op0b",  32'(iss_op[0]),  32'h33);
        tick();
        fu_ready = '0;
        chk("pri_free2", 32'(free_count), 32'd12);
        chk("pri_issv2", 32'(iss_valid),  32'd0);

        // ---- flush discards same-cycle dispatch and wakeup
        lane(0, 8'hE0, 2'd0, 6'd28, 6'd1, 1'b1, 6'd2, 1'b1);
        lane(1, 8'hE1, 2'd1, 6'd29, 6'd1, 1'b1, 6'd2, 1'b1);
        disp_valid  = 2'b11;
        wake_tag[0] = 6'd40;
        wake_valid  = 2'b01;
        flush       = 1'b1;
        tick();
        flush      = 1'b0;
        disp_valid = '0;
        wake_valid = '0;
        chk("fl3_free", 32'(free_count), 32'd16);
        chk("fl3_issv", 32'(iss_valid),  32'd0);
        tick();
        chk("fl3_issv2", 32'(iss_valid), 32'd0);

        // ---- asynchronous reset mid-cycle
        lane(0, 8'h5A, 2'd0, 6'd33, 6'd1, 1'b1, 6'd2, 1'b1);
        disp_valid = 2'b01;
        tick();
        disp_valid = '0;
        chk("ar_pre_issv", 32'(iss_valid),  32'b001);
        chk("ar_pre_op0",  32'(iss_op[0]),  32'h5A);
        chk("ar_pre_free", 32'(free_count), 32'd15);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_issv",  32'(iss_valid),  32'd0);
        chk("ar_op0",   32'(iss_op[0]),  32'd0);
        chk("ar_free",  32'(free_count), 32'd16);
        chk("ar_ready", 32'(disp_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        tick();
        chk("ar_post_issv", 32'(iss_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
